// File: rtl/bit_serial_pkg.sv
// rtl/bit_serial_pkg.sv - shared types and constants for the bit-serial ALU controller
package bit_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;

  typedef enum logic [1:0] {
    OP_NOR = 2'b00,
    OP_XOR = 2'b01,
    OP_ADD = 2'b10,
    OP_SUB = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } ctrl_state_e;

  // ADD and SUB are the only ops whose carry chain is meaningful
  function automatic logic is_arith(alu_op_e op);
    return op[1];
  endfunction

endpackage

// File: rtl/bsa_bit_counter.sv
// rtl/bsa_bit_counter.sv - bit position counter for the serial ALU sequencer
module bsa_bit_counter #(
  parameter int WIDTH = 8,
  localparam int CW = $clog2(WIDTH)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic last_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign last_o = (cnt_q == CW'(WIDTH - 1));

endmodule

// File: rtl/bit_serial_alu_ctrl.sv
// rtl/bit_serial_alu_ctrl.sv - drives a 1-bit ALU slice LSB first over WIDTH cycles
// Optional signed overflow output enabled by BIT_SERIAL_OVF_EN.
module bit_serial_alu_ctrl
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             alu_a,
  output logic             alu_b,
  output logic             alu_cin,
  output logic [1:0]       alu_op,
  input  logic             alu_s,
  input  logic             alu_cout
);

  ctrl_state_e      state_q;
  alu_op_e          op_q;
  logic [WIDTH-1:0] a_sh_q;
  logic [WIDTH-1:0] b_sh_q;
  logic [WIDTH-1:0] res_sh_q;
  logic [WIDTH-1:0] res_sh_d;
  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             cout_q;
  logic             busy_q;
  logic             done_q;
  logic             accept;
  logic             bit_last;

  assign accept   = start && (state_q == S_IDLE || state_q == S_DONE);
  assign res_sh_d = {alu_s, res_sh_q[WIDTH-1:1]};

  bsa_bit_counter #(.WIDTH(WIDTH)) u_bit_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr_i  (accept),
    .en_i   (state_q == S_RUN),
    .last_o (bit_last)
  );

`ifdef BIT_SERIAL_OVF_EN
  logic ovf_q;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= OP_NOR;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      res_sh_q <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
      cout_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef BIT_SERIAL_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE, S_DONE: begin
          if (accept) begin
            a_sh_q  <= a;
            b_sh_q  <= b;
            op_q    <= alu_op_e'(op);
            carry_q <= (alu_op_e'(op) == OP_SUB);
            busy_q  <= 1'b1;
            state_q <= S_RUN;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_RUN: begin
          a_sh_q   <= a_sh_q >> 1;
          b_sh_q   <= b_sh_q >> 1;
          res_sh_q <= res_sh_d;
          carry_q  <= alu_cout;
          if (bit_last) begin
            state_q  <= S_DONE;
            busy_q   <= 1'b0;
            done_q   <= 1'b1;
            result_q <= res_sh_d;
            cout_q   <= is_arith(op_q) & alu_cout;
`ifdef BIT_SERIAL_OVF_EN
            // carry_q here is the carry into the MSB; it differs from carry-out on signed overflow
            ovf_q    <= is_arith(op_q) & (carry_q ^ alu_cout);
`endif
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign result  = result_q;
  assign cout    = cout_q;
  assign alu_a   = a_sh_q[0];
  assign alu_b   = b_sh_q[0];
  assign alu_cin = carry_q;
  assign alu_op  = op_q;

`ifdef BIT_SERIAL_OVF_EN
  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule

// File: doc/bit_serial_alu_ctrl.md
Name: bit_serial_alu_ctrl

Overview:
- Sequencer that performs WIDTH-bit NOR/XOR/ADD/SUB on a single external 1-bit ALU slice, one bit per cycle, LSB first.
- Latches operands, drives the slice's a/b/cin/op each cycle and registers the slice's carry-out between bits.
- Assembles the result in a shift register and reports it with a one-cycle done pulse.
- Sits between a host (start/result handshake) and one 1-bit ALU instance.

Parameters:
- WIDTH, 8, operand/result width in bits (>= 2).

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  request; sampled in IDLE or DONE
- a  in  WIDTH  operand A, latched on accepted start
- b  in  WIDTH  operand B, latched on accepted start
- op  in  2  00 NOR, 01 XOR, 10 ADD, 11 SUB; latched on accepted start
- busy  out  1  high in RUN
- done  out  1  one-cycle pulse, result valid
- result  out  WIDTH  final result, held until next accepted start
- cout  out  1  final carry (ADD/SUB only, else 0), held like result
- ovf  out  1  signed overflow (see Optional Feature)
- alu_a  out  1  current bit of latched A to the slice
- alu_b  out  1  current bit of latched B to the slice
- alu_cin  out  1  carry into the slice
- alu_op  out  2  latched op to the slice
- alu_s  in  1  slice sum/logic output
- alu_cout  in  1  slice carry-out

Behaviour:
- Interface and reset: one clock, clk. Reset is synchronous and active-low on rst_n.
- While rst_n=0 at a clock edge: state=IDLE; busy, done, result, cout and ovf=0; operand, result shift and carry registers=0; bit counter=0.
- Reset asserted mid-RUN aborts the operation. No done is produced.
- States:
  - IDLE: start=1 latches a, b, op; sets bit counter=0; loads carry=(op==11); goes to RUN.
  - RUN: every cycle the result shift register shifts right with alu_s entering the MSB; the A/B shift registers shift right; carry<=alu_cout; counter++. After the cycle with counter==WIDTH-1, go to DONE.
  - DONE: done=1 for exactly this cycle. result and cout are updated at entry.
    - start=1 in DONE is accepted as in IDLE and goes to RUN (back-to-back).
    - Otherwise go to IDLE.
- Slice drive:
  - alu_a=A_sh[0], alu_b=B_sh[0], alu_op=latched op, alu_cin=carry register.
  - These are combinational from registers only; alu_s/alu_cout are consumed in the same cycle (single-cycle combinational loop through the slice).
  - The slice handles B inversion for SUB. The controller only supplies the initial cin (1 for SUB, 0 otherwise).
  - For NOR/XOR the carry register is still clocked but ignored. cout is forced to 0.
- Latency: start sampled at edge 0; RUN occupies edges 1..WIDTH; done is high in the cycle after edge WIDTH. Throughput is one op per WIDTH+1 cycles.
- start while busy is ignored (no queueing). Operand changes on a/b/op while busy have no effect.
- result and cout are not updated during RUN. They hold the previous values until DONE.
- SUB cout=1 means no borrow (A>=B unsigned).

Optional Feature:
- Macro: BIT_SERIAL_OVF_EN.
- Defined:
  - Capture the carry into the MSB, i.e. the carry register value at the counter==WIDTH-1 cycle.
  - At DONE, ovf=carry_in_msb XOR final carry for ADD/SUB; ovf=0 for NOR/XOR. Held like result.
- Undefined: ovf is tied 0. The port list is unchanged.

Decomposition:
- Package bit_serial_pkg:
  - alu_op_e enum (OP_NOR=2'b00, OP_XOR=2'b01, OP_ADD=2'b10, OP_SUB=2'b11).
  - ctrl_state_e (S_IDLE, S_RUN, S_DONE).
  - Default width constant.
- One sub-module, bsa_bit_counter: a $clog2(WIDTH)-bit counter with clear, enable and last (counter==WIDTH-1) outputs.
- Shift registers and FSM stay in the top.

Test Plan (WIDTH=8, a real 1-bit ALU slice attached):
- ADD a=0x5A b=0x33 -> done 9 cycles after start edge, result=0x8D, cout=0, busy high exactly 8 cycles.
- SUB a=0x10 b=0x01 -> result=0x0F, cout=1; SUB a=0x01 b=0x02 -> result=0xFF, cout=0.
- NOR a=0xF0 b=0x0C -> result=0x03, cout=0; XOR a=0xFF b=0x0F -> result=0xF0.
- ADD a=0xFF b=0x01 -> result=0x00, cout=1.
  - start pulsed again during RUN is ignored.
  - start held in the DONE cycle with XOR 0xAA^0x55 -> second done 9 cycles later, result=0xFF.
- rst_n low for one edge during RUN cycle 4 of ADD 0x12+0x34 -> next cycle IDLE, all outputs 0, no done.
  - Next op ADD 0x12+0x34 -> 0x46.
- BIT_SERIAL_OVF_EN: ADD 0x7F+0x01 -> result=0x80, ovf=1; SUB 0x80-0x01 -> 0x7F, ovf=1; ADD 0x01+0x01 -> ovf=0.
  - Macro undefined: ovf=0 always.
